// File: rtl/db9md_pkg.sv
// Shared constants for the DB9 Mega Drive pad scanner: output bit positions
// and the per-pad scan step indices.
package db9md_pkg;

  localparam int unsigned BIT_R     = 0;
  localparam int unsigned BIT_L     = 1;
  localparam int unsigned BIT_D     = 2;
  localparam int unsigned BIT_U     = 3;
  localparam int unsigned BIT_B     = 4;
  localparam int unsigned BIT_C     = 5;
  localparam int unsigned BIT_A     = 6;
  localparam int unsigned BIT_START = 7;
  localparam int unsigned BIT_MODE  = 8;
  localparam int unsigned BIT_X     = 9;
  localparam int unsigned BIT_Y     = 10;
  localparam int unsigned BIT_Z     = 11;

  localparam logic [2:0] P_DIR    = 3'd0;
  localparam logic [2:0] P_ID     = 3'd1;
  localparam logic [2:0] P_SIX    = 3'd5;
  localparam logic [2:0] P_EXT    = 3'd6;
  localparam logic [2:0] P_COMMIT = 3'd7;

  localparam int unsigned IDLE_START = 16;

endpackage

// File: rtl/db9md_tick_gen.sv
// Free-running prescaler: one-clock tick on the last clock of every
// STEP_DIV-clock scan step.
module db9md_tick_gen #(
  parameter int unsigned STEP_DIV = 384
) (
  input  logic clk,
  input  logic RESET,
  output logic tick
);
  localparam int unsigned   CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/db9md_pad_scanner.sv
// Scans two Mega Drive / Atari pads sharing one DB9 line set and presents
// each as a 16-bit active-high button word, updated once per scan frame.
module db9md_pad_scanner
  import db9md_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 384,
  parameter int unsigned FRAME_STEPS = 256
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2
);
  localparam int unsigned   SW     = $clog2(FRAME_STEPS);
  localparam logic [SW-1:0] S_LAST = SW'(FRAME_STEPS - 1);
  localparam logic [SW-1:0] S_IDLE = SW'(IDLE_START);
  localparam logic [SW-1:0] S_PAD2 = SW'(8);

  logic [5:0]    sync1, sync2, n;
  logic          tick, active, sample;
  logic [SW-1:0] s;
  logic [2:0]    p;
  logic [15:0]   shadow, shadow_nxt, commit_word;
  logic          md, md_nxt, six, six_nxt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= joy_in;
      sync2 <= sync1;
    end
  end

  db9md_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .RESET(RESET),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)          s <= '0;
    else if (tick)      s <= (s == S_LAST) ? '0 : s + 1'b1;
  end

  assign active    = (s < S_IDLE);
  assign p         = s[2:0];
  assign sample    = tick & active;
  assign n         = ~sync2;
  assign joy_split = (s >= S_PAD2);
  // Even steps drive SELECT high; the long idle-high lets the pad's
  // internal phase counter time out before the next pass.
  assign joy_mdsel = active ? ~s[0] : 1'b1;

  always_comb begin
    shadow_nxt = shadow;
    md_nxt     = md;
    six_nxt    = six;
    case (p)
      P_DIR: begin
        shadow_nxt        = '0;
        shadow_nxt[BIT_U] = n[0];
        shadow_nxt[BIT_D] = n[1];
        shadow_nxt[BIT_L] = n[2];
        shadow_nxt[BIT_R] = n[3];
        shadow_nxt[BIT_B] = n[4];
        shadow_nxt[BIT_C] = n[5];
        md_nxt            = 1'b0;
        six_nxt           = 1'b0;
      end
      P_ID: begin
        md_nxt                = ~sync2[2] & ~sync2[3];
        shadow_nxt[BIT_A]     = n[4];
        shadow_nxt[BIT_START] = n[5];
      end
      P_SIX: six_nxt = (sync2[3:0] == 4'b0000);
      P_EXT: begin
        shadow_nxt[BIT_Z]    = n[0];
        shadow_nxt[BIT_Y]    = n[1];
        shadow_nxt[BIT_X]    = n[2];
        shadow_nxt[BIT_MODE] = n[3];
      end
      default: ;
    endcase
  end

  always_comb begin
    commit_word = shadow;
    if (!md) begin
      commit_word[BIT_A]     = 1'b0;
      commit_word[BIT_START] = 1'b0;
    end
    if (!six) begin
      commit_word[BIT_MODE] = 1'b0;
      commit_word[BIT_X]    = 1'b0;
      commit_word[BIT_Y]    = 1'b0;
      commit_word[BIT_Z]    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      shadow    <= '0;
      md        <= 1'b0;
      six       <= 1'b0;
      joystick1 <= '0;
      joystick2 <= '0;
    end else if (sample) begin
      shadow <= shadow_nxt;
      md     <= md_nxt;
      six    <= six_nxt;
      if (p == P_COMMIT) begin
        if (s[3]) joystick2 <= commit_word;
        else      joystick1 <= commit_word;
      end
    end
  end

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Directed bench with behavioural 3/6-button pad models and a commit scoreboard.
module tb_db9md_pad_scanner;
  localparam int unsigned SD    = 16;
  localparam int unsigned FS    = 32;
  localparam int unsigned FRAME = SD * FS;
  localparam int          TMO   = 3 * SD;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_mdsel, joy_split;
  logic [15:0] joystick1, joystick2;

  logic [5:0]  def_in;
  logic        def_mdsel, def_split;
  logic [15:0] def_j1, def_j2;

  always #5 clk = ~clk;

  db9md_pad_scanner #(.STEP_DIV(SD), .FRAME_STEPS(FS)) dut (
    .clk(clk), .RESET(RESET), .joy_in(joy_in), .joy_mdsel(joy_mdsel),
    .joy_split(joy_split), .joystick1(joystick1), .joystick2(joystick2)
  );

  db9md_pad_scanner u_def (
    .clk(clk), .RESET(RESET), .joy_in(def_in), .joy_mdsel(def_mdsel),
    .joy_split(def_split), .joystick1(def_j1), .joystick2(def_j2)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc;

  always @(posedge clk or posedge RESET)
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;

  // pad kinds: 0 none, 3 three-button, 6 six-button; btn uses output bit layout
  int          kind1 = 0, kind2 = 0;
  logic [15:0] btn1 = '0, btn2 = '0;
  int          lows1 = 0, lows2 = 0, hic1 = 0, hic2 = 0;
  logic        psel1 = 1'b1, psel2 = 1'b1;
  logic        sel1, sel2;

  assign sel1 = joy_split ? 1'b1 : joy_mdsel;
  assign sel2 = joy_split ? joy_mdsel : 1'b1;

  always @(posedge clk) begin
    psel1 <= sel1;
    hic1  <= sel1 ? hic1 + 1 : 0;
    if (psel1 && !sel1) lows1 <= lows1 + 1;
    if (hic1 > TMO)     lows1 <= 0;
    psel2 <= sel2;
    hic2  <= sel2 ? hic2 + 1 : 0;
    if (psel2 && !sel2) lows2 <= lows2 + 1;
    if (hic2 > TMO)     lows2 <= 0;
  end

  function automatic logic [5:0] pad_lines(int kind, logic [15:0] b, logic sel, int lows);
    logic [5:0] pr;
    pr = '0;
    if (kind == 0) return 6'h3f;
    if (sel) begin
      if (kind == 6 && lows == 3) pr = {b[5], b[4], b[8], b[9], b[10], b[11]};
      else                        pr = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (kind == 6 && lows >= 4)      pr = '0;
      else if (kind == 6 && lows == 3) pr = {b[7], b[6], 4'b1111};
      else                             pr = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~pr;
  endfunction

  assign joy_in = joy_split ? pad_lines(kind2, btn2, sel2, lows2)
                            : pad_lines(kind1, btn1, sel1, lows1);

  typedef struct { int pad; logic [15:0] val; } exp_t;
  exp_t sbq[$];

  task automatic push(int pad, logic [15:0] v);
    exp_t e;
    e.pad = pad;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      check(tag, (e.pad == 1) ? joystick1 : joystick2, e.val);
    end
  endtask

  task automatic wait_until(int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned r1, r2, f1;
    int          toggles, idle_bad;
    logic        prev;

    def_in = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_j1", joystick1, 0);
    check("rst_j2", joystick2, 0);
    check("rst_mdsel", joy_mdsel, 1);
    check("rst_split", joy_split, 0);
    @(negedge clk) RESET = 1'b0;

    // frame 0: six-button pad 1 with A + Z, no pad 2
    kind1 = 6; btn1 = 16'h0840;
    push(1, 16'h0840); push(2, 16'h0000);
    wait_until(127); check("f0_j1_early", joystick1, 0);
    wait_until(128); pop_check("f0_j1");
    wait_until(256); pop_check("f0_j2");

    // frame 1: three-button pad 2 with Up + Start
    wait_until(300);
    kind1 = 0; btn1 = '0; kind2 = 3; btn2 = 16'h0088;
    push(1, 16'h0000); push(2, 16'h0088);
    wait_until(640); pop_check("f1_j1");
    wait_until(768); pop_check("f1_j2");
    check("f1_j2_ext", 32'(joystick2[11:8]), 0);

    // frame 2: no pads; count SELECT toggles and check idle level
    wait_until(800);
    kind2 = 0; btn2 = '0;
    push(1, 16'h0000); push(2, 16'h0000);
    wait_until(1024);
    prev = joy_mdsel; toggles = 0; idle_bad = 0;
    for (int unsigned c = 1025; c <= 1536; c++) begin
      wait_until(c);
      if (joy_mdsel !== prev) toggles++;
      prev = joy_mdsel;
      if (c < 1536 && (c - 1024) / SD >= 16 && joy_mdsel !== 1'b1) idle_bad++;
      if (c == 1152) pop_check("f2_j1");
      if (c == 1280) pop_check("f2_j2");
    end
    check("f2_toggles", toggles, 16);
    check("f2_idle_high", idle_bad, 0);

    // frame 3: pad 1 B, A added at s=3 (after its sample step)
    wait_until(1300);
    kind1 = 3; btn1 = 16'h0010;
    push(1, 16'h0010); push(2, 16'h0000);
    wait_until(1584); btn1 = 16'h0050;
    wait_until(1585); check("f3_j1_s3", joystick1, 0);
    wait_until(1663); check("f3_j1_pre", joystick1, 0);
    wait_until(1664); pop_check("f3_j1");
    wait_until(1792); pop_check("f3_j2");

    // frame 4: A now seen
    wait_until(1800);
    push(1, 16'h0050); push(2, 16'h0000);
    wait_until(2176); pop_check("f4_j1");
    wait_until(2304); pop_check("f4_j2");

    // frame 5: reset at s=5
    wait_until(2400);
    kind1 = 6; btn1 = 16'h0002;
    wait_until(2643);
    RESET = 1'b1;
    #1;
    check("mid_rst_j1", joystick1, 0);
    check("mid_rst_j2", joystick2, 0);
    check("mid_rst_mdsel", joy_mdsel, 1);
    check("mid_rst_split", joy_split, 0);
    repeat (64) @(posedge clk);
    @(negedge clk) RESET = 1'b0;
    push(1, 16'h0002); push(2, 16'h0000);
    wait_until(127); check("post_rst_j1_early", joystick1, 0);
    wait_until(128); pop_check("post_rst_j1");
    wait_until(256); pop_check("post_rst_j2");

    // default parameters: first step boundary and step period
    while (def_mdsel === 1'b1 && cyc < 2000) begin @(posedge clk); #1; end
    check("def_first_tick", cyc, 384);
    f1 = cyc;
    while (def_mdsel === 1'b0 && cyc < 3000) begin @(posedge clk); #1; end
    check("def_tick_period", cyc - f1, 384);

    // frame period of the scaled instance
    while (joy_split !== 1'b0 && cyc < 10000) begin @(posedge clk); #1; end
    while (joy_split !== 1'b1 && cyc < 10000) begin @(posedge clk); #1; end
    r1 = cyc;
    while (joy_split !== 1'b0 && cyc < 10000) begin @(posedge clk); #1; end
    while (joy_split !== 1'b1 && cyc < 10000) begin @(posedge clk); #1; end
    r2 = cyc;
    check("frame_period", r2 - r1, FRAME);
    while (joy_mdsel !== 1'b0 && cyc < 10000) begin @(posedge clk); #1; end
    r1 = cyc;
    while (joy_mdsel !== 1'b1 && cyc < 10000) begin @(posedge clk); #1; end
    check("step_period", cyc - r1, SD);

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/db9md_pad_scanner.md
DB9MD_PAD_SCANNER -- requirements
Module: db9md_pad_scanner

Interface
REQ-001 SHALL have parameter STEP_DIV, default 384, giving clk cycles per scan step (8 us at 48 MHz).
REQ-002 SHALL have parameter FRAME_STEPS, default 256, giving steps per full scan frame (2.048 ms).
REQ-003 SHALL have port clk, input, 1, system clock (48 MHz nominal); one clock only.
REQ-004 SHALL have port RESET, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port joy_in, input, 6, shared DB9 lines, active-low: [0] Up, [1] Down, [2] Left, [3] Right, [4] pin6 (B/A), [5] pin9 (C/Start).
REQ-006 SHALL have port joy_mdsel, output, 1, pad SELECT line.
REQ-007 SHALL have port joy_split, output, 1, pad mux select: 0 = pad 1, 1 = pad 2.
REQ-008 SHALL have ports joystick1 and joystick2, output, 16 each, active-high: [0] R, [1] L, [2] D, [3] U, [4] B, [5] C, [6] A, [7] Start, [8] Mode, [9] X, [10] Y, [11] Z, [15:12] constant 0.

Function
REQ-009 SHALL pass joy_in through a 2-flop synchronizer before any use.
REQ-010 SHALL generate a step tick, one clk wide, every STEP_DIV clocks from a free-running prescaler.
REQ-011 SHALL keep a step counter s, 0..FRAME_STEPS-1, advanced on the tick and wrapping FRAME_STEPS-1 -> 0.
REQ-012 SHALL drive joy_split = 0 for s in 0..7 and 1 for all other s.
REQ-013 SHALL drive joy_mdsel: for s in 0..15, high on even (s mod 8) and low on odd; high for s >= 16 (idle gives pad counter reset > 1.6 ms).
REQ-014 SHALL sample synchronized lines on the final clk of each active step (prescaler = STEP_DIV-1); no samples are taken in idle.
REQ-015 SHALL decode per pad step p = s mod 8, with n = inverted synchronized lines:
- p=0: U, D, L, R, B, C <- n[3:0], n[4], n[5].
- p=1: MD flag <- both raw Left and Right low; A, Start <- n[4], n[5].
- p=5: SIX flag <- raw Up, Down, Left and Right all low.
- p=6: Z, Y, X, Mode <- n[0], n[1], n[2], n[3].
REQ-016 SHALL hold decoded values in a shadow register and commit to joystick1 (s=7) or joystick2 (s=15) on the p=7 sample edge, atomically in one clk.
REQ-017 SHALL force A and Start to 0 in the committed word when MD = 0 (2-button or Atari pad).
REQ-018 SHALL force X, Y, Z and Mode to 0 in the committed word when SIX = 0 (3-button pad).
REQ-019 SHALL clear MD and SIX at p=0 of every pad pass.
REQ-020 SHALL hold joystick1/2 stable between commits, giving latency of at most one frame plus 2 clk sync.
REQ-021 SHALL report all lines high (no pad) as all-zero outputs: MD = 0, SIX = 0, U/D/L/R/B/C = 0.

Reset
REQ-022 SHALL, while RESET = 1, force prescaler = 0, s = 0, shadow = 0, MD = SIX = 0, joystick1 = joystick2 = 0, joy_mdsel = 1, joy_split = 0.
REQ-023 SHALL resume after RESET deasserts with s = 0 and the first tick STEP_DIV clocks later; a reset mid-frame discards the partial shadow with no commit.

Structure
REQ-024 SHALL place output bit-index constants (R..Z) and the step constants (P_DIR=0, P_ID=1, P_SIX=5, P_EXT=6, P_COMMIT=7, IDLE_START=16) in package db9md_pkg.
REQ-025 SHALL implement the prescaler as sub-module db9md_tick_gen (parameter STEP_DIV; ports clk, RESET, tick); all other logic is inline.

Verification
REQ-026 SHALL cover: 6-button pad model on pad 1 with A + Z pressed -> after one frame joystick1 = 16'h0840, joystick2 = 0.
REQ-027 SHALL cover: 3-button pad on pad 2 with Up + Start pressed -> joystick2 = 16'h0088 and bits [11:8] = 0.
REQ-028 SHALL cover: all lines held high -> both outputs 0; joy_mdsel toggles exactly 16 times per frame and stays high for steps 16..255.
REQ-029 SHALL cover: button change mid-frame at s=3 on pad 1 -> joystick1 changes only at the s=7 commit clk, never earlier.
REQ-030 SHALL cover: RESET asserted at s=5 -> outputs 0 immediately, joy_mdsel = 1, no commit until s=7 of the next full pass.
REQ-031 SHALL cover: prescaler and s wrap -> tick period exactly 384 clk, frame exactly 98304 clk (STEP_DIV=384, FRAME_STEPS=256).
